// File: rtl/sobel_load_controller_if.sv
// Handshake/bus bundle for the Sobel frame-read sequencer.
// With ROW_END_EN defined, the bundle also carries Row_End.
interface sobel_load_controller_if #(
    parameter int NumOfBit = 8,
    parameter int ADDR_W   = 16
);
    logic                Start;
    logic                Out_Ready;
    logic                Mem_Rd_En;
    logic [ADDR_W-1:0]   Mem_Addr;
    logic                Pixel_Valid;
    logic [NumOfBit-1:0] Pixel_Row;
    logic [NumOfBit-1:0] Pixel_Col;
    logic                Window_Valid;
    logic                Busy;
    logic                Done;
`ifdef ROW_END_EN
    logic                Row_End;
`endif

    modport master (
        input  Start, Out_Ready,
        output Mem_Rd_En, Mem_Addr, Pixel_Valid, Pixel_Row, Pixel_Col,
`ifdef ROW_END_EN
        output Row_End,
`endif
        output Window_Valid, Busy, Done
    );

    modport slave (
        output Start, Out_Ready,
        input  Mem_Rd_En, Mem_Addr, Pixel_Valid, Pixel_Row, Pixel_Col,
`ifdef ROW_END_EN
        input  Row_End,
`endif
        input  Window_Valid, Busy, Done
    );
endinterface

// File: rtl/sobel_load_controller.sv
// Raster-order frame-read sequencer: issues pixel reads, tags returned pixels with row/col
// and flags full 3x3 windows. Optional Row_End output under macro ROW_END_EN.
module sobel_load_controller #(
    parameter int NumOfBit = 8,
    parameter int IMG_W    = 256,
    parameter int IMG_H    = 256,
    parameter int ADDR_W   = 16
) (
    input logic CLK,
    input logic Reset,
    sobel_load_controller_if.master bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [NumOfBit-1:0] COL_LAST = NumOfBit'(IMG_W - 1);
    localparam logic [NumOfBit-1:0] ROW_LAST = NumOfBit'(IMG_H - 1);
    localparam logic [NumOfBit-1:0] WIN_MIN  = NumOfBit'(2);

    logic [1:0]          state;
    logic [NumOfBit-1:0] row, col;
    logic [ADDR_W-1:0]   addr;
    logic                rd_en, last_px;
    logic                pix_vld, win_vld;
    logic [NumOfBit-1:0] pix_row, pix_col;

    assign rd_en   = (state == S_READ) && bus.Out_Ready;
    assign last_px = (row == ROW_LAST) && (col == COL_LAST);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state   <= S_IDLE;
            row     <= '0;
            col     <= '0;
            addr    <= '0;
            pix_vld <= 1'b0;
            win_vld <= 1'b0;
            pix_row <= '0;
            pix_col <= '0;
        end else begin
            // Memory has 1-cycle latency, so the tag simply trails the read by one register.
            pix_vld <= rd_en;
            pix_row <= row;
            pix_col <= col;
            win_vld <= rd_en && (row >= WIN_MIN) && (col >= WIN_MIN);
            case (state)
                S_IDLE: begin
                    if (bus.Start) begin
                        state <= S_READ;
                        row   <= '0;
                        col   <= '0;
                        addr  <= '0;
                    end
                end
                S_READ: begin
                    if (rd_en) begin
                        // Counters and address stop on the last pixel rather than wrapping.
                        if (last_px) begin
                            state <= S_DRAIN;
                        end else begin
                            addr <= addr + 1'b1;
                            if (col == COL_LAST) begin
                                col <= '0;
                                row <= row + 1'b1;
                            end else begin
                                col <= col + 1'b1;
                            end
                        end
                    end
                end
                S_DRAIN: state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ROW_END_EN
    logic row_end;
    always_ff @(posedge CLK) begin
        if (Reset) row_end <= 1'b0;
        else       row_end <= rd_en && (col == COL_LAST);
    end
    assign bus.Row_End = row_end;
`endif

    assign bus.Mem_Rd_En    = rd_en;
    assign bus.Mem_Addr     = addr;
    assign bus.Pixel_Valid  = pix_vld;
    assign bus.Pixel_Row    = pix_row;
    assign bus.Pixel_Col    = pix_col;
    assign bus.Window_Valid = win_vld;
    assign bus.Busy         = (state == S_READ) || (state == S_DRAIN);
    assign bus.Done         = (state == S_DONE);
endmodule

// File: tb/tb_sobel_load_controller.sv
// Randomized bench for sobel_load_controller against a pixel-index reference model.
module tb_sobel_load_controller;
    localparam int NB = 8, W = 4, H = 3, AW = 4, N = W * H;

    logic CLK = 1'b0;
    logic Reset;
    always #5 CLK = ~CLK;

    sobel_load_controller_if #(.NumOfBit(NB), .ADDR_W(AW)) bus ();

    sobel_load_controller #(.NumOfBit(NB), .IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .CLK(CLK), .Reset(Reset), .bus(bus)
    );

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask

    // Reference: a frame is a count of pixels issued so far; the tail is drain then done.
    bit in_frame = 0;
    int issued   = 0;
    int tail     = 0;   // cycles since the last pixel was issued (1 = drain, 2 = done)
    bit prev_rd  = 0;
    int prev_idx = 0;
    bit just_rst = 0;
    int frames   = 0;

    function automatic bit reading();
        return in_frame && issued < N;
    endfunction

    task automatic check_outputs();
        bit exp_rd;
        int r, c;
        exp_rd = reading() && bus.Out_Ready;
        chk("busy", bus.Busy, reading() || (in_frame && tail == 1));
        chk("done", bus.Done, in_frame && tail == 2);
        chk("rd_en", bus.Mem_Rd_En, exp_rd);
        chk("addr", bus.Mem_Addr, (issued < N) ? issued : N - 1);
        chk("pix_vld", bus.Pixel_Valid, prev_rd);
        r = prev_idx / W;
        c = prev_idx % W;
        if (prev_rd) begin
            chk("pix_row", bus.Pixel_Row, r);
            chk("pix_col", bus.Pixel_Col, c);
        end else if (just_rst) begin
            chk("pix_row_rst", bus.Pixel_Row, 0);
            chk("pix_col_rst", bus.Pixel_Col, 0);
        end
        chk("win_vld", bus.Window_Valid, prev_rd && r >= 2 && c >= 2);
`ifdef ROW_END_EN
        chk("row_end", bus.Row_End, prev_rd && c == W - 1);
`endif
    endtask

    task automatic model_step();
        bit rd;
        rd = reading() && bus.Out_Ready;
        if (Reset) begin
            in_frame = 0; issued = 0; tail = 0; prev_rd = 0; prev_idx = 0; just_rst = 1;
            return;
        end
        just_rst = 0;
        prev_rd  = rd;
        if (rd) prev_idx = issued;
        if (in_frame) begin
            if (issued < N) begin
                if (rd) begin
                    issued++;
                    if (issued == N) tail = 1;
                end
            end else if (tail == 1) begin
                tail = 2;
            end else begin
                in_frame = 0;
                tail = 0;
                frames++;
            end
        end else if (bus.Start) begin
            in_frame = 1; issued = 0; tail = 0;
        end
    endtask

    task automatic cycle(input bit rst, input bit st, input bit rdy, input bit do_chk);
        @(negedge CLK);
        Reset = rst;
        bus.Start = st;
        bus.Out_Ready = rdy;
        #1;
        if (do_chk) check_outputs();
        model_step();
    endtask

    initial begin
        Reset = 1'b1;
        bus.Start = 1'b0;
        bus.Out_Ready = 1'b0;
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        // Idle after reset: nothing moves without Start, Out_Ready notwithstanding.
        for (int i = 0; i < 10; i++) cycle(0, 0, i[0], 1);
        // One clean frame with full readiness.
        cycle(0, 1, 1, 1);
        for (int i = 0; i < 20; i++) cycle(0, 0, 1, 1);
        // Randomized: sporadic Start, backpressure and the occasional mid-frame reset.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 249) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 3) != 0), 1);
        end
        for (int i = 0; i < 30; i++) cycle(0, 0, 1, 1);
        $display("frames completed: %0d", frames);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
